// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them from address 0, and holds the core in reset meanwhile.
module imem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned LEN_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_words_i,
  input  logic             abort_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  input  logic [31:0]      fetch_addr_i,
  output logic [31:0]      mem_addr_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_wdata_o,
  output logic             core_rst_no,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;

  logic [LEN_W-1:0] r_word_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_word_q;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic             r_core_rst_n;

  logic             w_hs;
  logic             w_last;
  logic             w_len_zero;
  logic             w_len_big;
  logic             w_done_set;
  logic             w_err_set;
  logic [31:0]      w_wr_addr;

  assign w_hs       = (r_state == S_RECV) && byte_valid_i;
  assign w_last     = (r_word_cnt + LEN_W'(1)) == r_len_q;
  assign w_len_zero = (len_words_i == '0);
  assign w_len_big  = (len_words_i > LEN_W'(MEM_DEPTH));
  assign w_wr_addr  = 32'({r_word_cnt, 2'b00});

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && !w_len_zero && !w_len_big) begin
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_hs && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort_i || w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and pulse requests; abort wins over completion
  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = fetch_addr_i;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_done_set = w_len_zero;
          w_err_set  = w_len_big;
        end
      end
      S_RECV: begin
        byte_ready_o = 1'b1;
        mem_addr_o   = w_wr_addr;
        w_err_set    = abort_i;
      end
      S_WRITE: begin
        mem_we_o   = 1'b1;
        mem_addr_o = w_wr_addr;
        w_err_set  = abort_i;
        w_done_set = !abort_i && w_last;
      end
      default: begin
        byte_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word_cnt   <= '0;
      r_len_q      <= '0;
      r_byte_idx   <= '0;
      r_word_q     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_core_rst_n <= 1'b1;
    end else begin
      r_done       <= w_done_set;
      r_err        <= w_err_set;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_core_rst_n <= (w_state_nxt == S_IDLE);
      if ((r_state == S_IDLE) && (w_state_nxt == S_RECV)) begin
        r_len_q    <= len_words_i;
        r_word_cnt <= '0;
        r_byte_idx <= '0;
      end
      if (w_hs && !abort_i) begin
        r_word_q[{r_byte_idx, 3'b000} +: 8] <= byte_data_i;
        r_byte_idx                          <= r_byte_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_word_cnt <= r_word_cnt + LEN_W'(1);
      end
    end
  end

  assign mem_wdata_o = r_word_q;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign core_rst_no = r_core_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: loads, stalls, rejects, aborts,
// full-depth load and mid-load reset.
module tb_imem_loader;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned LEN_W     = 9;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len_words;
  logic             abort;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [31:0]      fetch_addr;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic             core_rst_n;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .len_words_i  (len_words),
    .abort_i      (abort),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .fetch_addr_i (fetch_addr),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .core_rst_no  (core_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write/pulse monitor sampled mid-cycle
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int viol_cnt = 0;
  int last_we_cyc = -1;
  int last_done_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (err) err_cnt = err_cnt + 1;
    if (busy && core_rst_n) viol_cnt = viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    start = 1'b1;
    len_words = len;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      step();
    end
    if (!ok) check("byte_hs_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          byte_valid = 1'b0;
          step();
        end
      end
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'(ok), 32'd1);
    step();
  endtask

  function automatic logic [31:0] full_word(input int i);
    return {8'h5A, 8'(i), 8'hC3, 8'(255 - i)};
  endfunction

  int wb, db, eb, vb, bad;
  logic [31:0] stall_words [3];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len_words = '0;
    abort = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    fetch_addr = 32'h40;
    stall_words[0] = 32'hDEADBEEF;
    stall_words[1] = 32'h00000093;
    stall_words[2] = 32'hCAFEF00D;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_core_rst_n_in_reset", 32'(core_rst_n), 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 32'h40);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd1);
    check("rst_zero_outs", {27'd0, byte_ready, mem_we, busy, done, err}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    step();

    // Two-word back-to-back load
    wb = wr_addr.size(); db = done_cnt; eb = err_cnt; vb = viol_cnt;
    do_start(9'd2);
    @(negedge clk);
    check("two_busy", 32'(busy), 32'd1);
    check("two_core_rst_n", 32'(core_rst_n), 32'd0);
    check("two_ready", 32'(byte_ready), 32'd1);
    step();
    send_word(32'h00000013, 1'b0);
    send_word(32'h000012B7, 1'b0);
    byte_valid = 1'b0;
    wait_idle();
    check("two_nwrites", 32'(wr_addr.size() - wb), 32'd2);
    if (wr_addr.size() - wb == 2) begin
      check("two_a0", wr_addr[wb], 32'h0);
      check("two_d0", wr_data[wb], 32'h00000013);
      check("two_a1", wr_addr[wb+1], 32'h4);
      check("two_d1", wr_data[wb+1], 32'h000012B7);
    end
    check("two_done_cnt", 32'(done_cnt - db), 32'd1);
    check("two_done_timing", 32'(last_done_cyc - last_we_cyc), 32'd1);
    check("two_err_cnt", 32'(err_cnt - eb), 32'd0);
    check("two_core_rst_viol", 32'(viol_cnt - vb), 32'd0);
    check("two_idle_addr", mem_addr, 32'h40);
    check("two_idle_core_rst_n", 32'(core_rst_n), 32'd1);

    // Three-word load with source stalls
    wb = wr_addr.size(); db = done_cnt;
    do_start(9'd3);
    for (int w = 0; w < 3; w++) send_word(stall_words[w], 1'b1);
    byte_valid = 1'b0;
    wait_idle();
    check("stall_nwrites", 32'(wr_addr.size() - wb), 32'd3);
    if (wr_addr.size() - wb == 3) begin
      for (int w = 0; w < 3; w++) begin
        check($sformatf("stall_a%0d", w), wr_addr[wb+w], 32'(4 * w));
        check($sformatf("stall_d%0d", w), wr_data[wb+w], stall_words[w]);
      end
    end
    check("stall_done_cnt", 32'(done_cnt - db), 32'd1);

    // Rejected starts
    wb = wr_addr.size(); db = done_cnt; eb = err_cnt;
    do_start(9'd257);
    @(negedge clk);
    check("big_err", 32'(err), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    step();
    do_start(9'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("rej_nwrites", 32'(wr_addr.size() - wb), 32'd0);
    check("rej_err_cnt", 32'(err_cnt - eb), 32'd1);
    check("rej_done_cnt", 32'(done_cnt - db), 32'd1);

    // Abort in RECV after two bytes of word 1
    wb = wr_addr.size(); db = done_cnt; eb = err_cnt;
    do_start(9'd3);
    send_word(32'h00100093, 1'b0);
    send_byte(8'h37);
    send_byte(8'h02);
    byte_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abr_err", 32'(err), 32'd1);
    check("abr_done", 32'(done), 32'd0);
    check("abr_core_rst_n", 32'(core_rst_n), 32'd1);
    repeat (4) step();
    check("abr_nwrites", 32'(wr_addr.size() - wb), 32'd1);
    if (wr_addr.size() - wb == 1) check("abr_d0", wr_data[wb], 32'h00100093);
    check("abr_done_cnt", 32'(done_cnt - db), 32'd0);
    check("abr_err_cnt", 32'(err_cnt - eb), 32'd1);

    // Abort coincident with the final WRITE
    wb = wr_addr.size(); db = done_cnt;
    do_start(9'd1);
    send_word(32'hA1B2C3D4, 1'b0);
    byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abw_we", 32'(mem_we), 32'd1);
    check("abw_wdata", mem_wdata, 32'hA1B2C3D4);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abw_err", 32'(err), 32'd1);
    check("abw_done", 32'(done), 32'd0);
    step();
    check("abw_nwrites", 32'(wr_addr.size() - wb), 32'd1);
    check("abw_done_cnt", 32'(done_cnt - db), 32'd0);

    // Full-depth load
    wb = wr_addr.size(); db = done_cnt;
    do_start(9'd256);
    for (int i = 0; i < 256; i++) send_word(full_word(i), 1'b0);
    byte_valid = 1'b0;
    wait_idle();
    check("full_nwrites", 32'(wr_addr.size() - wb), 32'd256);
    bad = 0;
    if (wr_addr.size() - wb == 256) begin
      for (int i = 0; i < 256; i++) begin
        if (wr_addr[wb+i] !== 32'(4 * i) || wr_data[wb+i] !== full_word(i)) bad++;
      end
      check("full_last_addr", wr_addr[wb+255], 32'h3FC);
      check("full_last_data", wr_data[wb+255], 32'h5AFFC300);
    end
    check("full_seq_bad", 32'(bad), 32'd0);
    check("full_done_cnt", 32'(done_cnt - db), 32'd1);
    check("full_done_timing", 32'(last_done_cyc - last_we_cyc), 32'd1);

    // Mid-load reset
    wb = wr_addr.size();
    do_start(9'd4);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_core_rst_n", 32'(core_rst_n), 32'd1);
    check("mrst_addr", mem_addr, 32'h40);
    repeat (2) step();
    rst_n = 1'b1;
    byte_data = 8'h77;
    repeat (6) step();
    byte_valid = 1'b0;
    check("mrst_nwrites", 32'(wr_addr.size() - wb), 32'd1);
    check("mrst_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
